// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
//
// Issue/complete controller between the EX stage and the radix-4 divider core.
// A DIV/DIVU request in EX starts the core with a one-cycle pulse and holds the
// pipeline until the core reports completion. The 64-bit result is then
// captured into the HI/LO write-data registers and written during a single
// DONE cycle, which is also when the pipeline advances. A flush in any state
// abandons the divide: the controller returns to IDLE, the stall is dropped in
// the flush cycle, and no HI/LO write happens.
//
// The core has no reset and keeps running an abandoned divide. Its late
// core_ready is harmless because ready is honored only in WAIT. A new start
// reloads the core, so a stale ready can never follow a re-issue.
//
// Optional feature (macro DIV_ZERO_BYPASS_EN):
//   When defined, a request with a zero divisor does not start the core. The
//   controller goes straight to DONE with HI = dividend, LO = 32'hFFFFFFFF
//   (one stall cycle, write in the following cycle). When undefined, a zero
//   divisor runs through the core like any other operand pair.
//
// Ports:
//   clk          in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   ex_div_req   in   valid DIV/DIVU in EX (held while ex_stall=1)
//   ex_div_sign  in   1 = DIV (signed), 0 = DIVU
//   ex_src_a     in   dividend [31:0]
//   ex_src_b     in   divisor [31:0]
//   flush        in   exception/ERET flush of EX and younger
//   ex_stall     out  hold EX and earlier stages
//   core_start   out  one-cycle start pulse to the divider core
//   core_sign    out  pass-through of ex_div_sign
//   core_a       out  pass-through of ex_src_a
//   core_b       out  pass-through of ex_src_b
//   core_busy    in   core busy (monitor only, not used for completion)
//   core_ready   in   one-cycle result-valid pulse from the core
//   core_result  in   [63:32] remainder, [31:0] quotient (sign-corrected)
//   hilo_we      out  HI/LO write enable (DONE and not flushed)
//   hi_wdata     out  registered remainder
//   lo_wdata     out  registered quotient
// -----------------------------------------------------------------------------
module div_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_div_req,
    input  logic        ex_div_sign,
    input  logic [31:0] ex_src_a,
    input  logic [31:0] ex_src_b,
    input  logic        flush,
    output logic        ex_stall,
    output logic        core_start,
    output logic        core_sign,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    input  logic        core_busy,
    input  logic        core_ready,
    input  logic [63:0] core_result,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        issue;

    // Completion is decided by core_ready alone; busy is kept for observation.
    logic        core_busy_unused;
    assign core_busy_unused = core_busy;

    // Operands and sign go to the core combinationally so that the start
    // pulse and the operands arrive in the same cycle.
    assign core_sign = ex_div_sign;
    assign core_a    = ex_src_a;
    assign core_b    = ex_src_b;

    assign hi_wdata  = hi_q;
    assign lo_wdata  = lo_q;

    // Gating with resetn keeps core_start/ex_stall low for the whole time
    // reset is asserted, even if EX still presents a request.
    assign issue = ex_div_req & ~flush & resetn;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        ex_stall   = 1'b0;
        core_start = 1'b0;
        hilo_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (issue) begin
`ifdef DIV_ZERO_BYPASS_EN
                    if (ex_src_b == 32'd0) begin
                        ex_stall = 1'b1;
                        hi_d     = ex_src_a;
                        lo_d     = 32'hFFFF_FFFF;
                        state_d  = S_DONE;
                    end else begin
                        ex_stall   = 1'b1;
                        core_start = 1'b1;
                        state_d    = S_WAIT;
                    end
`else
                    ex_stall   = 1'b1;
                    core_start = 1'b1;
                    state_d    = S_WAIT;
`endif
                end
            end

            S_WAIT: begin
                // Flush wins over a coincident ready: the result is dropped.
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    ex_stall = 1'b1;
                    if (core_ready) begin
                        hi_d    = core_result[63:32];
                        lo_d    = core_result[31:0];
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // The request still visible in EX is the instruction that is
                // completing now, so it is not re-issued.
                hilo_we = ~flush;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
//
// Scoreboard bench for div_ctrl. A behavioural divider core (variable latency,
// no reset, start has priority) answers the controller. The stimulus process
// issues directed and random divides, pushing the expected HI/LO pair when a
// write must occur; a monitor pops and compares on every hilo_we.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

`ifdef DIV_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ex_div_req = 1'b0;
    logic        ex_div_sign = 1'b0;
    logic [31:0] ex_src_a = '0;
    logic [31:0] ex_src_b = '0;
    logic        flush = 1'b0;
    logic        ex_stall;
    logic        core_start;
    logic        core_sign;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_busy;
    logic        core_ready;
    logic [63:0] core_result;
    logic        hilo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_starts  = 0;
    int seen_starts = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .ex_div_req  (ex_div_req),
        .ex_div_sign (ex_div_sign),
        .ex_src_a    (ex_src_a),
        .ex_src_b    (ex_src_b),
        .flush       (flush),
        .ex_stall    (ex_stall),
        .core_start  (core_start),
        .core_sign   (core_sign),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_busy   (core_busy),
        .core_ready  (core_ready),
        .core_result (core_result),
        .hilo_we     (hilo_we),
        .hi_wdata    (hi_wdata),
        .lo_wdata    (lo_wdata)
    );

    // Reference division: {remainder, quotient}. Zero divisor yields
    // quotient all-ones and remainder = dividend (what the core produces).
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb_ = longint'($signed(b));
            q = sa / sb_;
            r = sa % sb_;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural divider core ----------------
    int          force_lat = 0;
    int          cur_lat = 1;
    int          age = 0;
    logic        busy_r = 1'b0;
    logic [63:0] res_r = '0;

    assign core_busy   = busy_r;
    assign core_ready  = busy_r && (age == cur_lat);
    assign core_result = res_r;

    always @(posedge clk) begin
        if (core_start) begin
            busy_r  <= 1'b1;
            age     <= 1;
            cur_lat <= (force_lat != 0) ? force_lat : int'($urandom_range(1, 8));
            res_r   <= ref_div(core_sign, core_a, core_b);
        end else if (busy_r) begin
            if (age == cur_lat) busy_r <= 1'b0;
            age <= age + 1;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (resetn && core_start) seen_starts++;
        if (resetn && hilo_we) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_hilo_we: got HI=%h LO=%h, required no write", hi_wdata, lo_wdata);
            end else begin
                check("hilo", {hi_wdata, lo_wdata}, sb.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            ex_div_req = 1'b0;
            flush = 1'b0;
            @(negedge clk);
        end
    endtask

    // mode 0: normal, 1: flush in first WAIT cycle, 2: flush in DONE
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b, input int mode);
        bit zb;
        bit done_next;
        int md, k, stalls;
        zb = BYP && (b == 32'd0);
        md = (mode == 1 && zb) ? 0 : mode;
        @(posedge clk); #1;
        ex_div_req = 1'b1;
        ex_div_sign = s;
        ex_src_a = a;
        ex_src_b = b;
        flush = 1'b0;
        if (md == 0) sb.push_back(zb ? {a, 32'hFFFF_FFFF} : ref_div(s, a, b));
        if (!zb) exp_starts++;
        @(negedge clk);
        check("issue_start", {63'd0, core_start}, {63'd0, !zb});
        check("issue_stall", {63'd0, ex_stall}, 64'd1);
        if (md == 1) begin
            @(posedge clk); #1;
            flush = 1'b1;
            @(negedge clk);
            check("flush_wait_stall", {63'd0, ex_stall}, 64'd0);
            return;
        end
        stalls = 1;
        done_next = zb;
        k = 1;
        forever begin
            @(posedge clk); #1;
            if (md == 2 && done_next) flush = 1'b1;
            @(negedge clk);
            if (!ex_stall) break;
            stalls++;
            done_next = core_ready;
            k++;
            if (k > 100) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stall_timeout: got stall for %0d cycles, required release", k);
                break;
            end
        end
        check("stall_cycles", 64'(stalls), 64'(zb ? 1 : cur_lat + 1));
        if (md == 2) check("flush_done_we", {63'd0, hilo_we}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int m, r;
        // reset state
        #3;
        check("rst_stall", {63'd0, ex_stall}, 64'd0);
        check("rst_start", {63'd0, core_start}, 64'd0);
        check("rst_we", {63'd0, hilo_we}, 64'd0);
        check("rst_hilo", {hi_wdata, lo_wdata}, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(2);

        // directed cases
        do_div(1'b0, 32'd100, 32'd7, 0);
        idle(1);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        idle(1);
        force_lat = 8;
        do_div(1'b0, 32'd77, 32'd5, 1);       // flushed, core keeps running
        force_lat = 0;
        idle(2);
        do_div(1'b0, 32'd9, 32'd3, 0);        // re-issue while stale divide active
        idle(10);
        do_div(1'b0, 32'd40, 32'd6, 2);       // flush coincides with DONE
        do_div(1'b0, 32'd9, 32'd3, 0);        // immediately after: back in IDLE
        idle(1);
        // flush together with a new request in IDLE
        @(posedge clk); #1;
        ex_div_req = 1'b1;
        ex_src_a = 32'd8;
        ex_src_b = 32'd2;
        flush = 1'b1;
        @(negedge clk);
        check("idle_flush_start", {63'd0, core_start}, 64'd0);
        check("idle_flush_stall", {63'd0, ex_stall}, 64'd0);
        idle(1);
        // back-to-back; request visible in DONE must not start a third divide
        do_div(1'b0, 32'd20, 32'd3, 0);
        do_div(1'b1, 32'd20, 32'hFFFF_FFFD, 0);
        idle(2);
        // divide by zero
        do_div(1'b0, 32'd5, 32'd0, 0);
        idle(2);

        // reset in the middle of WAIT
        force_lat = 8;
        @(posedge clk); #1;
        ex_div_req = 1'b1;
        ex_div_sign = 1'b0;
        ex_src_a = 32'd50;
        ex_src_b = 32'd5;
        exp_starts++;
        @(negedge clk);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        check("arst_stall", {63'd0, ex_stall}, 64'd0);
        check("arst_start", {63'd0, core_start}, 64'd0);
        check("arst_we", {63'd0, hilo_we}, 64'd0);
        check("arst_hilo", {hi_wdata, lo_wdata}, 64'd0);
        ex_div_req = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        force_lat = 0;
        idle(12);                              // stale core_ready must not write

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      rb = 32'd0;
            else if (r < 4)  rb = $urandom_range(1, 15);
            else             rb = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            r = $urandom_range(0, 19);
            m = (r < 14) ? 0 : (r < 17 ? 1 : 2);
            do_div(1'($urandom_range(0, 1)), ra, rb, m);
            r = $urandom_range(0, 3);
            if (r != 0) idle(r);
        end
        idle(12);

        check("pending_writes", 64'(sb.size()), 64'd0);
        check("start_count", 64'(seen_starts), 64'(exp_starts));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Issue/complete controller that drives the radix-4 divider core from the EX stage. It accepts DIV/DIVU requests, starts the core, and stalls the pipeline until the core signals completion. It then writes the 64-bit result into the HI/LO register file and handles flushes that arrive while a divide is in flight.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- ex_div_req  in  1  valid DIV/DIVU in EX; held while ex_stall=1.
- ex_div_sign  in  1  1=DIV (signed), 0=DIVU.
- ex_src_a  in  32  dividend.
- ex_src_b  in  32  divisor.
- flush  in  1  exception/ERET flush of EX and younger.
- ex_stall  out  1  hold EX and earlier stages.
- core_start  out  1  one-cycle start pulse to the divider core.
- core_sign  out  1  = ex_div_sign (combinational pass-through).
- core_a, core_b  out  32  = ex_src_a / ex_src_b (combinational pass-through).
- core_busy  in  1  core busy.
- core_ready  in  1  core one-cycle result-valid pulse.
- core_result  in  64  [63:32] = remainder, [31:0] = quotient, sign-corrected.
- hilo_we  out  1  HI/LO write enable.
- hi_wdata, lo_wdata  out  32  HI = remainder, LO = quotient.

## Operation
- States: IDLE, WAIT, DONE. 2-bit encoded.
- IDLE:
  - If ex_div_req=1 and flush=0: core_start=1 and ex_stall=1 in the same cycle, then go to WAIT.
  - Otherwise stay in IDLE with ex_stall=0.
- WAIT:
  - ex_stall=1.
  - On core_ready=1: register core_result into hi_wdata/lo_wdata, then go to DONE.
  - core_busy is monitor-only. Completion is decided by core_ready alone.
- DONE:
  - One cycle. ex_stall=0, hilo_wdata stable, hilo_we = !flush.
  - ex_div_req is still the same instruction in this cycle and is ignored.
  - Next state is IDLE.
- Flush, in any state:
  - Next state is IDLE.
  - No core_start, no hilo_we.
  - ex_stall=0 in the flush cycle.
- Abandoned core operation: the core has no reset, so a flushed divide keeps running inside it.
  - Its late core_ready is ignored, because ready is honored only in WAIT.
  - A new start reloads the core immediately. The core gives start priority, so no stale ready can appear after a re-issue.
- Reset values: state=IDLE, ex_stall=0, core_start=0, hilo_we=0, hi_wdata=0, lo_wdata=0.
- Reset mid-WAIT: return to IDLE. The core result that follows is ignored.

## Timing
- Cycle 0 (IDLE, req): core_start=1, ex_stall=1.
- Cycles 1..N: WAIT. N is the variable core latency; the core skips leading zero digits.
- Cycle N: core_ready sampled.
- Cycle N+1 (DONE): hilo_we=1, ex_stall=0. The pipeline advances at the end of this cycle.
- Total stall: N+1 cycles, counting cycle 0. Minimum turnaround between back-to-back divides is N+2 cycles.
- hi_wdata/lo_wdata are registered. hilo_we is combinational: DONE & !flush.

## Configuration
- Macro: DIV_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, a request with ex_src_b==0 does not start the core.
  - Go directly to DONE with hi_wdata=ex_src_a and lo_wdata=32'hFFFFFFFF.
  - Stall is 1 cycle; hilo_we follows in the next cycle.
- Undefined: divide-by-zero runs through the core like any other operand pair. HI/LO receive whatever the core produces.

## Test plan
- DIVU 100/7 -> one hilo_we pulse with HI=0x00000002, LO=0x0000000E; ex_stall high from the issue cycle until DONE.
- DIV 0xFFFFFFF9 (-7) / 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- Flush during WAIT -> ex_stall=0 in the flush cycle and no hilo_we. The later core_ready is ignored. A following DIVU 9/3 gives HI=0, LO=3.
- Flush coinciding with DONE -> hilo_we=0, state=IDLE. Flush with a new request in IDLE -> no core_start.
- Back-to-back DIVU 20/3 then DIV 20/0xFFFFFFFD (-3):
  - Exactly two hilo_we pulses: (HI=2, LO=6), then (HI=2, LO=0xFFFFFFFA).
  - The request seen in DONE does not start a third divide.
- ex_src_b=0, DIVU 5/0:
  - With DIV_ZERO_BYPASS_EN: no core_start, hilo_we one cycle after the request, HI=5, LO=0xFFFFFFFF.
  - Without it: core_start=1 and ex_stall is held until core_ready.
- resetn low mid-WAIT -> all outputs reset immediately and asynchronously. The core_ready that follows causes no write.
